// File: rtl/ex_muldiv_unit.sv
// Iterative multiply/divide unit for the EX stage; owns the HI/LO registers.
// MULT/MULTU/DIV/DIVU take XLEN/UNROLL iteration cycles plus one fix-up cycle;
// MTHI/MTLO write HI/LO on the accepting edge.
module ex_muldiv_unit #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned UNROLL = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            Stall,
  input  logic            Flush,
  input  logic            Start,
  input  logic [2:0]      Op,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  output logic            Busy,
  output logic            Done,
  output logic [XLEN-1:0] Hi,
  output logic [XLEN-1:0] Lo
);

  localparam int unsigned N  = XLEN / UNROLL;
  localparam int unsigned CW = $clog2(N) + 1;
  localparam int unsigned PW = 2 * XLEN;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic [XLEN-1:0] r_m, w_m_nxt;         // multiplicand or divisor magnitude
  logic [PW-1:0]   r_acc, w_acc_nxt;     // mul: {partial, multiplier}; div: {rem, quotient}
  logic            r_is_div, w_is_div_nxt;
  logic            r_neg_q, w_neg_q_nxt; // operand signs differ
  logic            r_neg_r, w_neg_r_nxt; // dividend negative
  logic            r_busy, w_busy_nxt;
  logic            r_done, w_done_nxt;
  logic [XLEN-1:0] r_hi, w_hi_nxt;
  logic [XLEN-1:0] r_lo, w_lo_nxt;

  logic            w_signed, w_sign_a, w_sign_b;
  logic [XLEN-1:0] w_mag_a, w_mag_b;
  logic [PW:0]     w_mt;
  logic [XLEN-1:0] w_rem, w_quo;
  logic [XLEN:0]   w_cand, w_diff;
  logic [PW-1:0]   w_step;
  logic [PW-1:0]   w_prod;
  logic [XLEN-1:0] w_q_fix, w_r_fix;

  assign Busy = r_busy;
  assign Done = r_done;
  assign Hi   = r_hi;
  assign Lo   = r_lo;

  // Operand sign and magnitude decode for the incoming op
  always_comb begin
    w_signed = (Op == OP_MULT) || (Op == OP_DIV);
    w_sign_a = w_signed & SrcA[XLEN-1];
    w_sign_b = w_signed & SrcB[XLEN-1];
    w_mag_a  = w_sign_a ? (-SrcA) : SrcA;
    w_mag_b  = w_sign_b ? (-SrcB) : SrcB;
  end

  // UNROLL shift-add or restoring-divide steps per cycle
  always_comb begin
    w_mt   = {1'b0, r_acc};
    w_rem  = r_acc[PW-1:XLEN];
    w_quo  = r_acc[XLEN-1:0];
    w_cand = '0;
    w_diff = '0;
    for (int k = 0; k < int'(UNROLL); k++) begin
      if (w_mt[0]) begin
        w_mt[PW:XLEN] = w_mt[PW:XLEN] + {1'b0, r_m};
      end
      w_mt = w_mt >> 1;
      w_cand = {w_rem, w_quo[XLEN-1]};
      w_quo  = {w_quo[XLEN-2:0], 1'b0};
      if (w_cand >= {1'b0, r_m}) begin
        w_diff   = w_cand - {1'b0, r_m};
        w_rem    = w_diff[XLEN-1:0];
        w_quo[0] = 1'b1;
      end else begin
        w_rem = w_cand[XLEN-1:0];
      end
    end
    w_step = r_is_div ? {w_rem, w_quo} : w_mt[PW-1:0];
  end

  // Sign fix-up of the finished magnitude result
  always_comb begin
    w_prod  = r_neg_q ? (-r_acc) : r_acc;
    w_q_fix = r_neg_q ? (-r_acc[XLEN-1:0]) : r_acc[XLEN-1:0];
    w_r_fix = r_neg_r ? (-r_acc[PW-1:XLEN]) : r_acc[PW-1:XLEN];
  end

  // Next-state and registered-output logic
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_m_nxt      = r_m;
    w_acc_nxt    = r_acc;
    w_is_div_nxt = r_is_div;
    w_neg_q_nxt  = r_neg_q;
    w_neg_r_nxt  = r_neg_r;
    w_busy_nxt   = r_busy;
    w_done_nxt   = 1'b0;
    w_hi_nxt     = r_hi;
    w_lo_nxt     = r_lo;
    if (Flush) begin
      w_state_nxt = S_IDLE;
      w_busy_nxt  = 1'b0;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (Start && !Stall) begin
            case (Op)
              OP_MULT, OP_MULTU: begin
                w_state_nxt  = S_MUL;
                w_busy_nxt   = 1'b1;
                w_cnt_nxt    = '0;
                w_is_div_nxt = 1'b0;
                w_m_nxt      = w_mag_a;
                w_acc_nxt    = {{XLEN{1'b0}}, w_mag_b};
                w_neg_q_nxt  = w_sign_a ^ w_sign_b;
                w_neg_r_nxt  = 1'b0;
              end
              OP_DIV, OP_DIVU: begin
                w_state_nxt  = S_DIV;
                w_busy_nxt   = 1'b1;
                w_cnt_nxt    = '0;
                w_is_div_nxt = 1'b1;
                w_m_nxt      = w_mag_b;
                w_acc_nxt    = {{XLEN{1'b0}}, w_mag_a};
                w_neg_q_nxt  = w_sign_a ^ w_sign_b;
                w_neg_r_nxt  = w_sign_a;
              end
              OP_MTHI: w_hi_nxt = SrcA;
              OP_MTLO: w_lo_nxt = SrcA;
              default: ;
            endcase
          end
        end
        S_MUL, S_DIV: begin
          w_acc_nxt = w_step;
          w_cnt_nxt = r_cnt + CW'(1);
          if (r_cnt == CW'(N - 1)) begin
            w_state_nxt = S_FIX;
          end
        end
        S_FIX: begin
          w_state_nxt = S_IDLE;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
          w_cnt_nxt   = '0;
          if (r_is_div) begin
            w_hi_nxt = w_r_fix;
            w_lo_nxt = w_q_fix;
          end else begin
            w_hi_nxt = w_prod[PW-1:XLEN];
            w_lo_nxt = w_prod[XLEN-1:0];
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_busy_nxt  = 1'b0;
        end
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_m      <= '0;
      r_acc    <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_m      <= w_m_nxt;
      r_acc    <= w_acc_nxt;
      r_is_div <= w_is_div_nxt;
      r_neg_q  <= w_neg_q_nxt;
      r_neg_r  <= w_neg_r_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
      r_hi     <= w_hi_nxt;
      r_lo     <= w_lo_nxt;
    end
  end

endmodule
